mem_port_arbiter: RTL

Arbitrates one shared single-ported memory between the instruction-fetch stage and the data-memory stage of the pipelined MIPS core. Fetches and loads/stores are issued to the memory one at a time, with variable wait states, and completion is returned to the requesting stage. While a stage's request is outstanding, its stall is asserted. Data accesses take priority, and a starvation counter bounds how long a fetch can be deferred.

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data wins arbitration; a saturating counter bounds how long a fetch can wait.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq,
  input  logic [31:0] iaddr,
  output logic [31:0] irdata,
  output logic        iready,
  output logic        istall,
  input  logic        dreq,
  input  logic        dwrite,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic        dready,
  output logic        dstall,
  output logic        mreq,
  output logic        mwrite,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  input  logic [31:0] mrdata,
  input  logic        mack
);

  localparam logic [3:0] LP_SMAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IBUSY,
    S_DBUSY
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_scnt;
  logic        r_iready;
  logic        r_dready;
  logic        r_mreq;
  logic        r_mwrite;
  logic [31:0] r_maddr;
  logic [31:0] r_mwdata;
  logic [31:0] r_irdata;
  logic [31:0] r_drdata;
  logic        w_dgrant;
  logic        w_igrant;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // No grant in the ready-pulse cycle: the finishing requester still holds its
  // request there, and a new request from the other port waits one IDLE cycle.
  always_comb begin
    w_next   = r_state;
    w_dgrant = 1'b0;
    w_igrant = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_iready && !r_dready) begin
          if (dreq && (!ireq || (r_scnt < LP_SMAX))) begin
            w_dgrant = 1'b1;
            w_next   = S_DBUSY;
          end else if (ireq) begin
            w_igrant = 1'b1;
            w_next   = S_IBUSY;
          end
        end
      end
      S_IBUSY, S_DBUSY: begin
        if (mack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scnt   <= '0;
      r_iready <= 1'b0;
      r_dready <= 1'b0;
      r_mreq   <= 1'b0;
      r_mwrite <= 1'b0;
      r_maddr  <= '0;
      r_mwdata <= '0;
      r_irdata <= '0;
      r_drdata <= '0;
    end else begin
      r_iready <= 1'b0;
      r_dready <= 1'b0;
      if (w_dgrant) begin
        r_mreq   <= 1'b1;
        r_mwrite <= dwrite;
        r_maddr  <= daddr;
        r_mwdata <= dwdata;
        if (!ireq)                r_scnt <= '0;
        else if (r_scnt < LP_SMAX) r_scnt <= r_scnt + 4'd1;
      end else if (w_igrant) begin
        r_mreq   <= 1'b1;
        r_mwrite <= 1'b0;
        r_maddr  <= iaddr;
        r_scnt   <= '0;
      end
      if (mack && (r_state == S_IBUSY)) begin
        r_irdata <= mrdata;
        r_iready <= 1'b1;
        r_mreq   <= 1'b0;
      end
      if (mack && (r_state == S_DBUSY)) begin
        r_dready <= 1'b1;
        r_mreq   <= 1'b0;
        if (!r_mwrite) r_drdata <= mrdata;
      end
    end
  end

  assign irdata = r_irdata;
  assign iready = r_iready;
  assign istall = ireq & ~r_iready;
  assign drdata = r_drdata;
  assign dready = r_dready;
  assign dstall = dreq & ~r_dready;
  assign mreq   = r_mreq;
  assign mwrite = r_mwrite;
  assign maddr  = r_maddr;
  assign mwdata = r_mwdata;

endmodule
